// File: rtl/register.sv
// register: WIDTH-bit storage register with write enable and synchronous reset
module register #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reg_write,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);
   logic [WIDTH-1:0] q;
   always_ff @(posedge clk)
      if (reset) q <= RESET_VALUE;
      else if (reg_write) q <= data_in;
   assign data_out = q;
endmodule

// File: tb/tb_register.sv
// tb_register: directed self-checking bench for register
module tb_register;
   logic clk = 1'b0;
   logic reset, reg_write;
   logic [31:0] data_in, data_out;
   int tests = 0, fails = 0;
   register #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .reg_write(reg_write),
      .data_in(data_in),
      .data_out(data_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step(input string tag, input logic r, input logic w, input logic [31:0] d, input logic [31:0] exp);
      @(negedge clk);
      reset = r;
      reg_write = w;
      data_in = d;
      @(posedge clk);
      #1 check(tag, data_out, exp);
   endtask
   initial begin
      reset = 1'b1;
      reg_write = 1'b0;
      data_in = 32'h0;
      step("reset1", 1, 0, 32'h0, 32'h0000_0000);
      step("reset2", 1, 0, 32'h0, 32'h0000_0000);
      step("write", 0, 1, 32'h1234_5678, 32'h1234_5678);
      step("hold", 0, 0, 32'h8765_4321, 32'h1234_5678);
      step("overwrite", 0, 1, 32'hABCD_EF01, 32'hABCD_EF01);
      step("rst_prio", 1, 1, 32'hDEAD_BEEF, 32'h0000_0000);
      step("post_rst", 0, 1, 32'h5555_5555, 32'h5555_5555);
      step("one", 0, 1, 32'h0000_0001, 32'h0000_0001);
      step("ones", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step("zeros", 0, 1, 32'h0000_0000, 32'h0000_0000);
      step("hold0", 0, 0, 32'hFFFF_FFFF, 32'h0000_0000);
      step("load_a5", 0, 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
      @(negedge clk);
      reset = 1'b1;
      data_in = 32'h3C3C_3C3C;
      #1 check("async_rst", data_out, 32'hA5A5_A5A5);
      reset = 1'b0;
      reg_write = 1'b1;
      data_in = 32'h0F0F_0F0F;
      #1 check("async_din", data_out, 32'hA5A5_A5A5);
      reset = 1'b1;
      @(posedge clk);
      #1 check("edge_rst", data_out, 32'h0000_0000);
      step("b2b_a", 0, 1, 32'hCAFE_0001, 32'hCAFE_0001);
      step("b2b_b", 0, 1, 32'hCAFE_0002, 32'hCAFE_0002);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
